// File: rtl/vip_uart_rx_decoder.sv
// UART receiver for the simulation fixture: decodes 8N1 frames into a byte FIFO drained over valid/ready.
// Define VIP_UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking on parity_err_o.
module vip_uart_rx_decoder #(
  parameter int BaudDiv   = 16,
  parameter int FifoDepth = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       uart_rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overflow_o,
  output logic       busy_o
);
  localparam int CNT_W  = $clog2(BaudDiv);
  localparam int ADDR_W = $clog2(FifoDepth);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BaudDiv / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BaudDiv - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef VIP_UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK_WAIT
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d;
  logic             rx_meta, rx_sync;
  logic             push, frame_err_d;
  logic             tick;

  logic [7:0]       mem [FifoDepth];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, pop, wr_en;

`ifdef VIP_UART_RX_PARITY_EN
  logic par_bit, par_bit_d, par_err_q, par_err_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
    end
  end

  assign tick = (cnt == '0);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    shift_d     = shift;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef VIP_UART_RX_PARITY_EN
    par_bit_d   = par_bit;
    par_err_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (rx_sync) begin
          state_d = IDLE;
        end else begin
          cnt_d     = FULL_LOAD;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          shift_d   = {rx_sync, shift[7:1]};
          cnt_d     = FULL_LOAD;
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef VIP_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef VIP_UART_RX_PARITY_EN
      PARITY: begin
        if (!tick) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          par_bit_d = rx_sync;
          cnt_d     = FULL_LOAD;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (!tick) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (!rx_sync) begin
          // Framing wins over parity; park until the line goes idle.
          frame_err_d = 1'b1;
          state_d     = BRK_WAIT;
        end else begin
          state_d = IDLE;
`ifdef VIP_UART_RX_PARITY_EN
          if ((^shift) != par_bit) par_err_d = 1'b1;
          else                     push      = 1'b1;
`else
          push = 1'b1;
`endif
        end
      end
      BRK_WAIT: begin
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_idx_d;
      frame_err_o <= frame_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shift <= shift_d;
  end

`ifdef VIP_UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) par_err_q <= 1'b0;
    else         par_err_q <= par_err_d;
  end

  always_ff @(posedge clk_i) begin
    par_bit <= par_bit_d;
  end

  assign parity_err_o = par_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop   = valid_o && ready_i;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      overflow_o <= push && full && !pop;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= shift;
  end

  assign valid_o = !empty;
  assign data_o  = valid_o ? mem[rd_ptr[ADDR_W-1:0]] : 8'h00;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_vip_uart_rx_decoder.sv
// Directed bench for vip_uart_rx_decoder: drives serial frames and checks delivered bytes, pulses and latency.
module tb_vip_uart_rx_decoder;
  localparam int B     = 16;
  localparam int DEPTH = 4;
`ifdef VIP_UART_RX_PARITY_EN
  localparam int  NBITS  = 11;
  localparam bit  PAR_EN = 1'b1;
`else
  localparam int  NBITS  = 10;
  localparam bit  PAR_EN = 1'b0;
`endif
  // Sync (2) + leave IDLE (1) + half bit + remaining whole bits up to the stop sample.
  localparam int PUSH_LAT = 3 + B / 2 + (NBITS - 1) * B;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       uart_rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overflow, busy;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int start_cyc, first_valid_cyc, valid_cycles, n_frame, n_par, n_ovf;
  logic [7:0] rx_q[$];

  vip_uart_rx_decoder #(.BaudDiv(B), .FifoDepth(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .uart_rx_i   (uart_rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .frame_err_o (frame_err),
    .parity_err_o(parity_err),
    .overflow_o  (overflow),
    .busy_o      (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (ready) rx_q.push_back(data);
    end
    if (frame_err)  n_frame++;
    if (parity_err) n_par++;
    if (overflow)   n_ovf++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    tick(B);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PAR_EN) send_bit((^b) ^ par_flip);
    send_bit(stop);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    first_valid_cyc = -1;
    valid_cycles    = 0;
    n_frame         = 0;
    n_par           = 0;
    n_ovf           = 0;
  endtask

  function automatic logic [31:0] qget(input int i);
    return (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD_BEEF;
  endfunction

  initial begin
    clear_mon();
    tick(3);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_parity_err", parity_err, 0);
    check_eq("rst_overflow", overflow, 0);
    rst_ni = 1'b1;
    tick(5);

    // Single byte with immediate acceptance
    ready = 1'b1;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(5);
    check_eq("single_count", rx_q.size(), 1);
    check_eq("single_data", qget(0), 32'hA5);
    check_eq("single_valid_cycles", valid_cycles, 1);
    check_eq("single_latency", first_valid_cyc - start_cyc, PUSH_LAT);
    check_eq("single_errs", n_frame + n_par + n_ovf, 0);
    check_eq("single_busy", busy, 0);

    // False start glitch
    clear_mon();
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(1);
    check_eq("false_busy_hi", busy, 1);
    tick(10);
    check_eq("false_busy_lo", busy, 0);
    check_eq("false_valid", valid_cycles, 0);
    check_eq("false_errs", n_frame + n_par + n_ovf, 0);

    // Framing error, held break, then recovery
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(40);
    check_eq("frame_pulses", n_frame, 1);
    check_eq("frame_no_push", valid_cycles, 0);
    check_eq("frame_break_busy", busy, 1);
    check_eq("frame_no_par", n_par, 0);
    uart_rx = 1'b1;
    tick(5);
    check_eq("frame_release_busy", busy, 0);
    send_frame(8'h42, 1'b1, 1'b0);
    tick(5);
    check_eq("frame_next_count", rx_q.size(), 1);
    check_eq("frame_next_data", qget(0), 32'h42);
    check_eq("frame_pulses_after", n_frame, 1);

    // Overflow with depth 4
    ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    tick(3);
    check_eq("ovf_pulses", n_ovf, 1);
    check_eq("ovf_valid", valid, 1);
    check_eq("ovf_head_stable", data, 32'h01);
    ready = 1'b1;
    tick(6);
    check_eq("ovf_pop_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("ovf_pop%0d", i), qget(i), 32'(i + 1));
    check_eq("ovf_valid_fall", valid, 0);

    // Pop and push in the same cycle while full
    ready = 1'b0;
    clear_mon();
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    tick(2);
    check_eq("simul_full_valid", valid, 1);
    fork
      send_frame(8'h14, 1'b1, 1'b0);
      begin
        tick(PUSH_LAT - 1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    tick(3);
    check_eq("simul_no_ovf", n_ovf, 0);
    check_eq("simul_one_pop", rx_q.size(), 1);
    ready = 1'b1;
    tick(8);
    check_eq("simul_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("simul_q%0d", i), qget(i), 32'h10 + 32'(i));

`ifdef VIP_UART_RX_PARITY_EN
    // Parity mismatch then correct parity
    clear_mon();
    send_frame(8'h01, 1'b1, 1'b1);
    tick(5);
    check_eq("par_bad_pulse", n_par, 1);
    check_eq("par_bad_dropped", valid_cycles, 0);
    check_eq("par_bad_no_frame", n_frame, 0);
    send_frame(8'h01, 1'b1, 1'b0);
    tick(5);
    check_eq("par_good_count", rx_q.size(), 1);
    check_eq("par_good_data", qget(0), 32'h01);
    check_eq("par_good_no_new_err", n_par, 1);
`endif

    // Reset in the middle of a frame with a byte buffered
    ready = 1'b0;
    clear_mon();
    send_frame(8'h77, 1'b1, 1'b0);
    tick(2);
    check_eq("mid_pre_valid", valid, 1);
    uart_rx = 1'b0;
    tick(60);
    check_eq("mid_pre_busy", busy, 1);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_data", data, 0);
    uart_rx = 1'b1;
    tick(3);
    rst_ni = 1'b1;
    tick(3 * B);
    check_eq("mid_no_errs", n_frame + n_par + n_ovf, 0);
    check_eq("mid_empty", valid, 0);
    ready = 1'b1;
    clear_mon();
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(5);
    check_eq("mid_after_count", rx_q.size(), 1);
    check_eq("mid_after_data", qget(0), 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vip_uart_rx_decoder.md
# vip_uart_rx_decoder

Serial receiver that sits directly downstream of the SoC's `uart_tx` pin in the simulation fixture. It decodes 8N1 frames (optionally 8E1) into bytes and buffers them in a small FIFO. The FIFO drains over a valid/ready interface to the bench console logger or scoreboard. The block is synthesizable, so it can also be reused on FPGA debug builds.

## Interface
- `BaudDiv`, default 16: clock cycles per bit. Must be >= 4.
- `FifoDepth`, default 8: byte FIFO entries. Must be a power of two, >= 2.
- `clk_i` in 1: single clock. Line sampling and FIFO both run on it.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `uart_rx_i` in 1: serial line from the DUT's `uart_tx`. Asynchronous to `clk_i`; idles high.
- `data_o` out 8: FIFO head byte.
- `valid_o` out 1: FIFO non-empty.
- `ready_i` in 1: consumer accepts the head byte.
- `frame_err_o` out 1: one-cycle pulse when a stop bit is sampled low.
- `parity_err_o` out 1: one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.
- `overflow_o` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy_o` out 1: high while the FSM is not in IDLE.

## Operation
- **Input synchronizer.** `uart_rx_i` passes through a two-flop synchronizer. Both flops reset to 1.
- **IDLE.** On synced line == 0, load the baud counter with `BaudDiv/2 - 1` and go to START.
- **START.** When the counter reaches 0, sample the line.
  - Line high: false start, return to IDLE with nothing reported.
  - Line low: reload counter with `BaudDiv - 1`, clear the bit index, go to DATA.
- **DATA.** Sample at each counter expiry and shift in LSB first. After the 8th bit, go to PARITY if compiled in, else STOP.
- **PARITY.** Sample one bit. Expected value is even parity over the 8 data bits (XOR of data == parity bit).
- **STOP.** Sample one bit.
  - High, no parity error: push the byte.
  - High, parity error: pulse `parity_err_o`, discard the byte.
  - Low: pulse `frame_err_o`, discard the byte, go to BREAK. Framing takes priority over parity; only `frame_err_o` pulses.
- **BREAK.** Wait for synced line == 1, then go to IDLE. This prevents a held-low line from retriggering.
- **FIFO push.** If the FIFO is full on a push, drop the incoming byte, keep existing contents, and pulse `overflow_o`.
- **FIFO pop.** Pop occurs on `valid_o && ready_i`. A push and pop in the same cycle while full is not an overflow: the pop frees the slot.
- **Output stability.** `data_o` holds steady while `valid_o && !ready_i`. `data_o` value is don't-care when `valid_o` is 0.
- **Pointers.** Read/write pointers are `$clog2(FifoDepth)+1` bits; full/empty are decided by the extra MSB. The baud counter is `$clog2(BaudDiv)` bits.

## Timing
- **Reset values.** `valid_o`, `frame_err_o`, `parity_err_o`, `overflow_o`, `busy_o` are 0; `data_o` is 0; FIFO empty; FSM in IDLE.
- **Start detection.** 2 cycles from the `uart_rx_i` falling edge to the synced edge, plus 1 cycle to leave IDLE.
- **Sample points.** Bit k (start = 0) is sampled `BaudDiv/2 + k*BaudDiv` cycles after the FSM leaves IDLE.
- **Push latency.** `valid_o` rises the cycle after the stop-bit sample if the FIFO was empty. Error pulses appear in the same cycle that `valid_o` would have risen.
- **Throughput.** Back-to-back frames with no idle gap are received without loss. The FSM returns to IDLE in the stop-bit sample cycle and can detect the next start half a bit later.
- **Reset mid-frame.** Asynchronous reset immediately clears the FSM and FIFO. A partial frame is lost and no error is reported.

## Configuration
- `VIP_UART_RX_PARITY_EN` defined: PARITY state exists, frames are 8E1, and `parity_err_o` is live.
- Not defined: frames are 8N1, there is no PARITY state, and `parity_err_o` is constant 0.

## Test plan
- **Single byte.** BaudDiv=16, `ready_i`=1, send 0xA5 8N1. Expect `valid_o` for exactly 1 cycle with `data_o`=0xA5, rising the cycle after the stop sample; no error pulses.
- **False start.** 3-cycle low glitch on an idle line. Expect `busy_o` to return low after the START sample, `valid_o` never set, no error pulses.
- **Framing error.** Send 0x3C with the stop bit low, hold the line low for 40 cycles, release, then send 0x42. Expect one `frame_err_o` pulse, no push for 0x3C, BREAK held until release, then 0x42 delivered.
- **Overflow.** FifoDepth=4, `ready_i`=0, send 0x01–0x05. Expect one `overflow_o` pulse on the 5th byte. Then raise `ready_i`: pops return 0x01, 0x02, 0x03, 0x04, and `valid_o` falls.
- **Backpressure and simultaneity.** FIFO full with `ready_i`=0; raise `ready_i` for exactly the cycle the next byte is pushed. Expect no overflow and FIFO order preserved.
- **Parity (macro defined).** Send 0x01 with parity bit 0: expect `parity_err_o` pulse and byte dropped. Then send 0x01 with parity bit 1: expect the byte delivered. Also apply reset mid-DATA and expect all outputs 0 and the FIFO empty.
